ft601_tx_scheduler: RTL and testbench



---
 rtl/ft601_tx_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_ft601_tx_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft601_tx_scheduler.sv
// Packet-granular round-robin scheduler feeding one FT601 multi-channel FIFO write port.
// Optional header word per packet: define FT601_TX_SCHED_HDR_EN.
module ft601_tx_scheduler #(
  parameter int unsigned NUM_SOURCES     = 4,
  parameter int unsigned MAX_PACKET_SIZE = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_SOURCES-1:0]     src_req,
  input  logic [32*NUM_SOURCES-1:0]  src_data,
  input  logic [4*NUM_SOURCES-1:0]   src_be,
  input  logic [NUM_SOURCES-1:0]     src_valid,
  input  logic [NUM_SOURCES-1:0]     src_last,
  output logic [NUM_SOURCES-1:0]     src_ready,
  output logic [31:0]                wr_data,
  output logic [3:0]                 wr_be,
  output logic                       wr_en,
  output logic                       wr_push,
  input  logic                       wr_full,
  input  logic                       wr_has_packet_space,
  output logic [2:0]                 grant_id,
  output logic                       busy
);
  localparam int unsigned MAX_WORDS = MAX_PACKET_SIZE / 4;
  localparam int unsigned WCNT_W    = $clog2(MAX_WORDS) + 1;

  typedef enum logic [1:0] {IDLE, ARB, XFER, PUSH} state_t;

  state_t                  state, state_d;
  logic [2:0]              rr_ptr, rr_ptr_d;
  logic [WCNT_W-1:0]       wcnt, wcnt_d, wcnt_inc;
  logic [2:0]              grant_d;
  logic [NUM_SOURCES-1:0]  src_ready_d;
  logic [31:0]             wr_data_d;
  logic [3:0]              wr_be_d;
  logic                    wr_en_d, wr_push_d, busy_d;

  logic [31:0]             g_data;
  logic [3:0]              g_be;
  logic                    g_last;
  logic                    accept;
  logic                    arb_found;
  logic [2:0]              arb_idx;

`ifdef FT601_TX_SCHED_HDR_EN
  logic [15:0]             seq [NUM_SOURCES];
  logic [15:0]             g_seq;
  logic                    hdr_phase, hdr_phase_d;
`endif

  assign wcnt_inc = wcnt + 1'b1;
  assign accept   = |(src_valid & src_ready);

  // Granted-source mux
  always_comb begin
    g_data = '0;
    g_be   = '0;
    g_last = 1'b0;
`ifdef FT601_TX_SCHED_HDR_EN
    g_seq  = '0;
`endif
    for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
      if (grant_id == 3'(i)) begin
        g_data = src_data[32*i +: 32];
        g_be   = src_be[4*i +: 4];
        g_last = src_last[i];
`ifdef FT601_TX_SCHED_HDR_EN
        g_seq  = seq[i];
`endif
      end
    end
  end

  // Round-robin search: offset k scans rr_ptr+1, rr_ptr+2, ... modulo NUM_SOURCES
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int unsigned k = 0; k < NUM_SOURCES; k++) begin
      for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
        if (!arb_found && src_req[i] &&
            i == (32'(rr_ptr) + 32'd1 + k) % NUM_SOURCES) begin
          arb_found = 1'b1;
          arb_idx   = 3'(i);
        end
      end
    end
  end

  always_comb begin
    state_d     = state;
    rr_ptr_d    = rr_ptr;
    wcnt_d      = wcnt;
    grant_d     = grant_id;
    src_ready_d = '0;
    wr_data_d   = wr_data;
    wr_be_d     = wr_be;
    wr_en_d     = 1'b0;
    wr_push_d   = 1'b0;
`ifdef FT601_TX_SCHED_HDR_EN
    hdr_phase_d = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (|src_req) state_d = ARB;
      end
      ARB: begin
        if (!(|src_req)) begin
          state_d = IDLE;
        end else if (wr_has_packet_space && arb_found) begin
          grant_d = arb_idx;
          wcnt_d  = '0;
          state_d = XFER;
`ifdef FT601_TX_SCHED_HDR_EN
          hdr_phase_d = 1'b1;
`else
          for (int unsigned i = 0; i < NUM_SOURCES; i++)
            if (arb_idx == 3'(i)) src_ready_d[i] = !wr_full;
`endif
        end
      end
      XFER: begin
        // Header cycle replaces the data-accept branch; src_ready is low then
`ifdef FT601_TX_SCHED_HDR_EN
        if (hdr_phase) begin
          wr_data_d = {8'hA5, 5'd0, grant_id, g_seq};
          wr_be_d   = '1;
          wr_en_d   = 1'b1;
          wcnt_d    = wcnt_inc;
        end else
`endif
        if (accept) begin
          wr_data_d = g_data;
          wr_be_d   = g_be;
          wr_en_d   = 1'b1;
          wcnt_d    = wcnt_inc;
          if (g_last || wcnt_inc == WCNT_W'(MAX_WORDS)) state_d = PUSH;
        end
        if (state_d == XFER) begin
          for (int unsigned i = 0; i < NUM_SOURCES; i++)
            if (grant_id == 3'(i)) src_ready_d[i] = !wr_full;
        end
      end
      PUSH: begin
        wr_push_d = 1'b1;
        rr_ptr_d  = grant_id;
        state_d   = ARB;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_d = (state_d != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= 3'(NUM_SOURCES - 1);
      wcnt      <= '0;
      grant_id  <= '0;
      src_ready <= '0;
      wr_data   <= '0;
      wr_be     <= '0;
      wr_en     <= 1'b0;
      wr_push   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      rr_ptr    <= rr_ptr_d;
      wcnt      <= wcnt_d;
      grant_id  <= grant_d;
      src_ready <= src_ready_d;
      wr_data   <= wr_data_d;
      wr_be     <= wr_be_d;
      wr_en     <= wr_en_d;
      wr_push   <= wr_push_d;
      busy      <= busy_d;
    end
  end

`ifdef FT601_TX_SCHED_HDR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hdr_phase <= 1'b0;
      for (int unsigned i = 0; i < NUM_SOURCES; i++) seq[i] <= '0;
    end else begin
      hdr_phase <= hdr_phase_d;
      if (state == PUSH) begin
        for (int unsigned i = 0; i < NUM_SOURCES; i++)
          if (grant_id == 3'(i)) seq[i] <= seq[i] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ft601_tx_scheduler.sv
// Scoreboard bench for ft601_tx_scheduler: random producers, packet-level round-robin reference model.
module tb_ft601_tx_scheduler;
  localparam int unsigned NS    = 4;
  localparam int unsigned MPS   = 1024;
  localparam int unsigned MW    = MPS / 4;
  localparam int unsigned DEPTH = 1024;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NS-1:0]        src_req = '0, src_valid = '0, src_last = '0;
  logic [NS-1:0]        src_ready;
  logic [32*NS-1:0]     src_data = '0;
  logic [4*NS-1:0]      src_be = '0;
  logic [31:0]          wr_data;
  logic [3:0]           wr_be;
  logic                 wr_en, wr_push;
  logic                 wr_full = 1'b0, wr_has_packet_space = 1'b1;
  logic [2:0]           grant_id;
  logic                 busy;

  ft601_tx_scheduler #(.NUM_SOURCES(NS), .MAX_PACKET_SIZE(MPS)) dut (
    .clk(clk), .reset(reset),
    .src_req(src_req), .src_data(src_data), .src_be(src_be),
    .src_valid(src_valid), .src_last(src_last), .src_ready(src_ready),
    .wr_data(wr_data), .wr_be(wr_be), .wr_en(wr_en), .wr_push(wr_push),
    .wr_full(wr_full), .wr_has_packet_space(wr_has_packet_space),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  // Stimulus store per source: {last, be, data}
  logic [36:0]  mem [NS][DEPTH];
  int unsigned  head [NS] = '{default: 0};
  int unsigned  tail [NS] = '{default: 0};

  // Scoreboard queues
  logic [35:0]  exp_words [$];
  logic [2:0]   exp_grant [$];
  int unsigned  exp_len [$];

  int unsigned  m_rr = NS - 1;
  logic [15:0]  m_seq [NS] = '{default: 16'd0};

  bit           force_nospace = 1'b0;
  int           full_cnt = 0;
  int unsigned  cur_n = 0;
  bit           prev_full = 1'b0, prev_en = 1'b0;
  logic [NS-1:0] acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event occurred, required none", name);
  endtask

  task automatic add_pkt(input int s, input int len, input bit fixed, input logic [31:0] base);
    for (int j = 0; j < len; j++) begin
      logic [31:0] d;
      logic [3:0]  b;
      d = fixed ? base + 32'(j) : $urandom;
      b = fixed ? 4'hF : 4'($urandom_range(1, 15));
      mem[s][tail[s]] = {(j == len - 1), b, d};
      tail[s]++;
    end
  endtask

  // Reference: pick next source with data round-robin, cut at last or at MW words
  task automatic model_build();
    int unsigned mh [NS];
    bit          more;
    int unsigned sel;
    int unsigned n;
    logic [36:0] w;
    for (int i = 0; i < NS; i++) mh[i] = head[i];
    more = 1'b1;
    while (more) begin
      more = 1'b0;
      sel  = 0;
      for (int unsigned k = 1; k <= NS; k++) begin
        int unsigned s;
        s = (m_rr + k) % NS;
        if (!more && mh[s] < tail[s]) begin
          more = 1'b1;
          sel  = s;
        end
      end
      if (more) begin
        n = 0;
`ifdef FT601_TX_SCHED_HDR_EN
        exp_words.push_back({4'hF, 8'hA5, 5'd0, 3'(sel), m_seq[sel]});
        n = 1;
`endif
        do begin
          w = mem[sel][mh[sel]];
          mh[sel]++;
          exp_words.push_back(w[35:0]);
          n++;
        end while (!w[36] && n < MW);
        exp_grant.push_back(3'(sel));
        exp_len.push_back(n);
        m_seq[sel] = m_seq[sel] + 16'd1;
        m_rr = sel;
      end
    end
  endtask

  task automatic prep();
    for (int i = 0; i < NS; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
  endtask

  task automatic wait_drain(input string name);
    int  c;
    bit  done;
    c    = 0;
    done = 1'b0;
    while (!done && c < 20000) begin
      @(posedge clk);
      #1;
      c++;
      done = (exp_grant.size() == 0) && !busy;
      for (int i = 0; i < NS; i++) if (head[i] < tail[i]) done = 1'b0;
    end
    chk({"drain_", name}, 64'(done), 64'd1);
  endtask

  // Producers and channel flags, driven just after the active edge
  always begin
    @(negedge clk);
    acc = src_valid & src_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++) begin
      if (acc[i] && head[i] < tail[i]) head[i]++;
      src_req[i]            = head[i] < tail[i];
      src_valid[i]          = (head[i] < tail[i]) && ($urandom_range(0, 99) < 85);
      src_data[32*i +: 32]  = mem[i][head[i]][31:0];
      src_be[4*i +: 4]      = mem[i][head[i]][35:32];
      src_last[i]           = mem[i][head[i]][36];
    end
    if (full_cnt > 0) begin
      wr_full = 1'b1;
      full_cnt--;
    end else begin
      wr_full = 1'b0;
      if ($urandom_range(0, 11) == 0) full_cnt = $urandom_range(1, 6);
    end
    wr_has_packet_space = !force_nospace && ($urandom_range(0, 9) != 0);
  end

  // Monitor
  always @(negedge clk) begin
    if (reset) begin
      cur_n     = 0;
      prev_en   = 1'b0;
      prev_full = 1'b0;
    end else begin
      if (src_ready != '0) chk("ready_only_grant", 64'(src_ready), 64'(NS'(1) << grant_id));
      if (prev_full) chk("ready_low_after_full", 64'(src_ready), 64'd0);
      if (wr_en) begin
        chk("en_push_overlap", 64'(wr_push), 64'd0);
        if (exp_words.size() == 0) fail("unexpected_word");
        else chk("word", 64'({wr_be, wr_data}), 64'(exp_words.pop_front()));
        cur_n++;
      end
      if (wr_push) begin
        chk("push_after_last_en", 64'(prev_en), 64'd1);
        if (exp_grant.size() == 0) fail("unexpected_push");
        else begin
          chk("pkt_grant", 64'(grant_id), 64'(exp_grant.pop_front()));
          chk("pkt_len", 64'(cur_n), 64'(exp_len.pop_front()));
        end
        cur_n = 0;
      end
      prev_en   = wr_en;
      prev_full = wr_full;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_src_ready", 64'(src_ready), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_wr_be", 64'(wr_be), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_push", 64'(wr_push), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Three simultaneous requesters right after reset: order 0,1,2
    @(negedge clk);
    prep();
    add_pkt(0, 2, 1'b1, 32'h100);
    add_pkt(1, 2, 1'b1, 32'h200);
    add_pkt(2, 2, 1'b1, 32'h300);
    model_build();
    wait_drain("three_way");

    // Source 0, words 0x1..0x4
    @(negedge clk);
    prep();
    add_pkt(0, 4, 1'b1, 32'h1);
    model_build();
    wait_drain("four_words");

    // Long stream forces a split at MW
    @(negedge clk);
    prep();
    add_pkt(1, 300, 1'b1, 32'h1000);
    model_build();
    wait_drain("split");

    // Single-word packets back to back
    @(negedge clk);
    prep();
    for (int p = 0; p < 3; p++) add_pkt(3, 1, 1'b0, 32'h0);
    add_pkt(2, 1, 1'b0, 32'h0);
    model_build();
    wait_drain("single_word");

    // No packet space: hold in ARB
    @(negedge clk);
    force_nospace = 1'b1;
    prep();
    add_pkt(2, 3, 1'b1, 32'h500);
    model_build();
    repeat (12) @(negedge clk);
    chk("nospace_busy", 64'(busy), 64'd1);
    chk("nospace_ready", 64'(src_ready), 64'd0);
    chk("nospace_wr_en", 64'(wr_en), 64'd0);
    force_nospace = 1'b0;
    wait_drain("nospace");

    // Random mixes
    for (int ph = 0; ph < 6; ph++) begin
      @(negedge clk);
      prep();
      for (int s = 0; s < NS; s++) begin
        int np;
        np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++) begin
          if ($urandom_range(0, 7) == 0) add_pkt(s, $urandom_range(250, 270), 1'b0, 32'h0);
          else add_pkt(s, $urandom_range(1, 12), 1'b0, 32'h0);
        end
      end
      model_build();
      wait_drain("random");
    end

    // Reset in the middle of a transfer
    @(negedge clk);
    prep();
    add_pkt(3, 60, 1'b1, 32'h7000);
    model_build();
    begin
      int c;
      c = 0;
      while (cur_n < 5 && c < 2000) begin
        @(negedge clk);
        c++;
      end
      chk("midxfer_started", 64'(cur_n >= 5), 64'd1);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    prep();
    exp_words.delete();
    exp_grant.delete();
    exp_len.delete();
    m_rr = NS - 1;
    for (int i = 0; i < NS; i++) m_seq[i] = 16'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("post_reset_push", 64'(wr_push), 64'd0);
      chk("post_reset_busy", 64'(busy), 64'd0);
    end

    // All sources after reset: source 0 first again
    @(negedge clk);
    prep();
    for (int s = 0; s < NS; s++) begin
      add_pkt(s, $urandom_range(1, 6), 1'b0, 32'h0);
      add_pkt(s, $urandom_range(1, 6), 1'b0, 32'h0);
    end
    model_build();
    wait_drain("post_reset_all");

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
